burst_config_sync: RTL and testbench
====================================

BURST_CONFIG_SYNC -- requirements
Module: burst_config_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for asynchronous inputs; legal values are 2 and 3.
REQ-002 SHALL have HF_CLK  input  1  clock; every flop is clocked on the rising edge.
REQ-003 SHALL have NRST_sync  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ENSAMP  input  1  asynchronous sampling enable from the register domain.
REQ-005 SHALL have CFG_REQ_TOG  input  1  asynchronous request toggle; each level change is one new configuration request.
REQ-006 SHALL have CFG_PHASE1DIV1  input  12  requested Phase-1 half-period divide value; asynchronous, stable from the request toggle until the acknowledge.
REQ-007 SHALL have CFG_PHASE1COUNT  input  4  requested pulses per burst; same stability rule as REQ-006.
REQ-008 SHALL have CFG_PHASE2COUNT  input  10  requested silence length in HF_CLK cycles; same stability rule as REQ-006.
REQ-009 SHALL have TEMP_RUN  input  1  temperature-run enable, in the HF_CLK domain.
REQ-010 SHALL have phase  input  1  divider phase flag (1 = Phase 2 silence), in the HF_CLK domain.
REQ-011 SHALL have CFG_ERR_CLR  input  1  single-cycle pulse in the HF_CLK domain that clears CFG_ERR.
REQ-012 SHALL have ENSAMP_sync  output  1  synchronized ENSAMP.
REQ-013 SHALL have PHASE1DIV1_sync, PHASE1COUNT_sync, PHASE2COUNT_sync  outputs  12/4/10  the active configuration fed to the burst divider.
REQ-014 SHALL have CFG_ACK_TOG  output  1  acknowledge toggle back to the register domain.
REQ-015 SHALL have CFG_PENDING  output  1  high while a captured request awaits its apply point.
REQ-016 SHALL have CFG_ERR  output  1  sticky rejected-request flag.

Function
REQ-017 SHALL pass ENSAMP and CFG_REQ_TOG through separate SYNC_STAGES-deep flop chains, giving req_s and ENSAMP_sync; no other input SHALL be synchronized.
REQ-018 SHALL detect a request when req_s differs from its one-cycle-delayed copy (req_d), and on that edge SHALL capture all three CFG_* buses into staging registers.
REQ-019 SHALL implement the FSM IDLE -> PENDING -> IDLE; a request edge in IDLE SHALL enter PENDING, and an apply SHALL return to IDLE.
REQ-020 SHALL assert CFG_PENDING exactly while the FSM is in PENDING.
REQ-021 SHALL define the safe condition as any of: (a) ENSAMP_sync=0 and TEMP_RUN=0; (b) phase rising edge, i.e. phase=1 while the registered phase from the previous cycle was 0; (c) active PHASE2COUNT_sync=0 (continuous mode).
REQ-022 SHALL perform the apply on the first edge in PENDING at which the safe condition holds, earliest one cycle after capture.
REQ-023 SHALL, on apply, load all three staging registers into the *_sync outputs in the same cycle, so outputs never show a mixed old/new configuration.
REQ-024 SHALL, on apply, set CFG_ACK_TOG equal to req_d.
REQ-025 SHALL, on a request edge while in PENDING, overwrite the staging registers, stay in PENDING, and issue a single acknowledge for the merged request.
REQ-026 SHALL treat a request edge in the same cycle as an apply as follows: the apply uses the old staging, the new values are captured, and the FSM stays in PENDING.
REQ-027 SHALL, on apply with staged PHASE1COUNT=0, leave the *_sync outputs unchanged, set CFG_ERR=1, still toggle the acknowledge, and return to IDLE.
REQ-028 SHALL clear CFG_ERR on CFG_ERR_CLR; if a set event occurs in the same cycle, the set SHALL win.
REQ-029 SHALL pass all values through without range modification other than REQ-027; widths SHALL be exact, with no arithmetic on the configuration fields.
REQ-030 SHALL give a worst-case latency, for SYNC_STAGES=2 with the safe condition already true, of 4 HF_CLK edges from the first edge sampling the new CFG_REQ_TOG level to the outputs updating.

Reset
REQ-031 SHALL, while NRST_sync=0, asynchronously force: all synchronizer flops, ENSAMP_sync, CFG_ACK_TOG, CFG_PENDING, CFG_ERR and PHASE1DIV1_sync to 0; PHASE1COUNT_sync to 1; PHASE2COUNT_sync to 0; FSM to IDLE; staging to the same values as the outputs.
REQ-032 SHALL, when reset is asserted mid-PENDING, discard the pending request with no acknowledge issued.
REQ-033 SHALL, after reset release, restart synchronization from the reset values, so a CFG_REQ_TOG held at 1 is seen as one new request.

Verification
REQ-034 SHALL cover: disabled, request {DIV1=5, COUNT=3, P2=20}, CFG_REQ_TOG 0->1 -> outputs update and ACK=1 on the 4th edge; PENDING high for 1 cycle.
REQ-035 SHALL cover: ENSAMP=1 with active P2=20, request {DIV1=8} -> PENDING holds, outputs unchanged until the cycle after phase rises, then update and ACK toggles.
REQ-036 SHALL cover: enabled in continuous mode (active P2=0), request {DIV1=2, COUNT=4, P2=0} -> applied 4 edges after the toggle.
REQ-037 SHALL cover: two toggles 3 cycles apart while pending (0->1->0) -> staging holds the second value, exactly one apply occurs, and final ACK=0.
REQ-038 SHALL cover: request with COUNT=0 while disabled -> outputs unchanged, CFG_ERR=1, ACK toggles; CFG_ERR_CLR pulse -> CFG_ERR=0.
REQ-039 SHALL cover: NRST_sync low while PENDING -> outputs 0/1/0, ACK=0, PENDING=0 immediately, with no update after release.

Source files
------------

// File: rtl/burst_config_sync.sv
// Moves a burst-divider configuration from the register domain into HF_CLK. The request
// crosses as a toggle, and the three fields are applied together at a burst-safe point.
module burst_config_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        HF_CLK,
   input  logic        NRST_sync,
   input  logic        ENSAMP,
   input  logic        CFG_REQ_TOG,
   input  logic [11:0] CFG_PHASE1DIV1,
   input  logic [3:0]  CFG_PHASE1COUNT,
   input  logic [9:0]  CFG_PHASE2COUNT,
   input  logic        TEMP_RUN,
   input  logic        phase,
   input  logic        CFG_ERR_CLR,
   output logic        ENSAMP_sync,
   output logic [11:0] PHASE1DIV1_sync,
   output logic [3:0]  PHASE1COUNT_sync,
   output logic [9:0]  PHASE2COUNT_sync,
   output logic        CFG_ACK_TOG,
   output logic        CFG_PENDING,
   output logic        CFG_ERR
);

   typedef enum logic {IDLE, PENDING} state_t;

   logic [SYNC_STAGES-1:0] en_chain_p0;
   logic [SYNC_STAGES-1:0] req_chain_p0;
   logic                   req_s;
   logic                   req_d_p1;
   logic                   req_edge;
   logic                   phase_d_p1;

   logic [11:0] stg_div_p1;
   logic [3:0]  stg_cnt_p1;
   logic [9:0]  stg_p2_p1;

   state_t state_p1;
   state_t state_nxt;
   logic   apply;
   logic   err_set;
   logic   safe;

   function automatic logic safe_point(input logic en_s, input logic temp_run,
                                       input logic ph, input logic ph_d,
                                       input logic [9:0] p2_active);
      safe_point = (!en_s && !temp_run) || (ph && !ph_d) || (p2_active == 10'd0);
   endfunction

   // Stage 0: synchronizer chains for the two asynchronous single-bit inputs
   always_ff @(posedge HF_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
         en_chain_p0  <= '0;
         req_chain_p0 <= '0;
      end else begin
         en_chain_p0  <= {en_chain_p0[SYNC_STAGES-2:0], ENSAMP};
         req_chain_p0 <= {req_chain_p0[SYNC_STAGES-2:0], CFG_REQ_TOG};
      end
   end

   assign ENSAMP_sync = en_chain_p0[SYNC_STAGES-1];
   assign req_s       = req_chain_p0[SYNC_STAGES-1];
   assign req_edge    = req_s ^ req_d_p1;

   assign safe = safe_point(ENSAMP_sync, TEMP_RUN, phase, phase_d_p1, PHASE2COUNT_sync);

   always_comb begin
      state_nxt = state_p1;
      apply     = 1'b0;
      case (state_p1)
         IDLE: begin
            if (req_edge) state_nxt = PENDING;
         end
         PENDING: begin
            apply = safe;
            // A request landing on the apply edge keeps us pending for the new values
            if (apply && !req_edge) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign err_set     = apply && (stg_cnt_p1 == 4'd0);
   assign CFG_PENDING = (state_p1 == PENDING);

   // Stage 1: edge detect, staging capture and FSM state
   always_ff @(posedge HF_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
         req_d_p1   <= 1'b0;
         phase_d_p1 <= 1'b0;
         state_p1   <= IDLE;
         stg_div_p1 <= 12'd0;
         stg_cnt_p1 <= 4'd1;
         stg_p2_p1  <= 10'd0;
      end else begin
         req_d_p1   <= req_s;
         phase_d_p1 <= phase;
         state_p1   <= state_nxt;
         if (req_edge) begin
            stg_div_p1 <= CFG_PHASE1DIV1;
            stg_cnt_p1 <= CFG_PHASE1COUNT;
            stg_p2_p1  <= CFG_PHASE2COUNT;
         end
      end
   end

   // Stage 2: active configuration, acknowledge and error flag
   always_ff @(posedge HF_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
         PHASE1DIV1_sync  <= 12'd0;
         PHASE1COUNT_sync <= 4'd1;
         PHASE2COUNT_sync <= 10'd0;
         CFG_ACK_TOG      <= 1'b0;
         CFG_ERR          <= 1'b0;
      end else begin
         if (apply && !err_set) begin
            PHASE1DIV1_sync  <= stg_div_p1;
            PHASE1COUNT_sync <= stg_cnt_p1;
            PHASE2COUNT_sync <= stg_p2_p1;
         end
         if (apply) CFG_ACK_TOG <= req_d_p1;
         if (err_set)          CFG_ERR <= 1'b1;
         else if (CFG_ERR_CLR) CFG_ERR <= 1'b0;
      end
   end

endmodule

// File: tb/tb_burst_config_sync.sv
// Directed bench for burst_config_sync: a request table applied while disabled,
// then hand-written sequences for gating, merging and reset corner cases.
module tb_burst_config_sync;

   logic        HF_CLK = 1'b0;
   logic        NRST_sync;
   logic        ENSAMP, CFG_REQ_TOG, TEMP_RUN, phase, CFG_ERR_CLR;
   logic [11:0] CFG_PHASE1DIV1;
   logic [3:0]  CFG_PHASE1COUNT;
   logic [9:0]  CFG_PHASE2COUNT;
   logic        ENSAMP_sync, CFG_ACK_TOG, CFG_PENDING, CFG_ERR;
   logic [11:0] PHASE1DIV1_sync;
   logic [3:0]  PHASE1COUNT_sync;
   logic [9:0]  PHASE2COUNT_sync;

   int total = 0;
   int bad   = 0;

   burst_config_sync #(.SYNC_STAGES(2)) dut (
      .HF_CLK(HF_CLK), .NRST_sync(NRST_sync), .ENSAMP(ENSAMP), .CFG_REQ_TOG(CFG_REQ_TOG),
      .CFG_PHASE1DIV1(CFG_PHASE1DIV1), .CFG_PHASE1COUNT(CFG_PHASE1COUNT),
      .CFG_PHASE2COUNT(CFG_PHASE2COUNT), .TEMP_RUN(TEMP_RUN), .phase(phase),
      .CFG_ERR_CLR(CFG_ERR_CLR), .ENSAMP_sync(ENSAMP_sync),
      .PHASE1DIV1_sync(PHASE1DIV1_sync), .PHASE1COUNT_sync(PHASE1COUNT_sync),
      .PHASE2COUNT_sync(PHASE2COUNT_sync), .CFG_ACK_TOG(CFG_ACK_TOG),
      .CFG_PENDING(CFG_PENDING), .CFG_ERR(CFG_ERR)
   );

   always #5 HF_CLK = ~HF_CLK;

   typedef struct {
      logic [11:0] div;
      logic [3:0]  cnt;
      logic [9:0]  p2;
      logic [11:0] e_div;
      logic [3:0]  e_cnt;
      logic [9:0]  e_p2;
      logic        e_err;
   } vec_t;

   vec_t tbl[5];

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge HF_CLK);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_cfg(input string name, input logic [11:0] d, input logic [3:0] c,
                          input logic [9:0] p);
      chk({name, "_div"}, 32'(PHASE1DIV1_sync), 32'(d));
      chk({name, "_cnt"}, 32'(PHASE1COUNT_sync), 32'(c));
      chk({name, "_p2"},  32'(PHASE2COUNT_sync), 32'(p));
   endtask

   task automatic request(input logic lvl, input logic [11:0] d, input logic [3:0] c,
                          input logic [9:0] p);
      CFG_PHASE1DIV1  = d;
      CFG_PHASE1COUNT = c;
      CFG_PHASE2COUNT = p;
      CFG_REQ_TOG     = lvl;
   endtask

   logic        lvl;
   logic [11:0] prev_div;
   logic [3:0]  prev_cnt;
   logic [9:0]  prev_p2;

   initial begin
      tbl[0] = '{12'd5,     4'd3,  10'd20,   12'd5,     4'd3,  10'd20,   1'b0};
      tbl[1] = '{12'hFFF,   4'd15, 10'd1023, 12'hFFF,   4'd15, 10'd1023, 1'b0};
      tbl[2] = '{12'd7,     4'd0,  10'd9,    12'hFFF,   4'd15, 10'd1023, 1'b1};
      tbl[3] = '{12'd1,     4'd1,  10'd0,    12'd1,     4'd1,  10'd0,    1'b1};
      tbl[4] = '{12'h123,   4'd8,  10'd0,    12'h123,   4'd8,  10'd0,    1'b1};

      NRST_sync = 1'b0; ENSAMP = 1'b0; TEMP_RUN = 1'b0; phase = 1'b0; CFG_ERR_CLR = 1'b0;
      lvl = 1'b0;
      request(1'b0, 12'd0, 4'd0, 10'd0);
      tick(3);
      chk_cfg("rst", 12'd0, 4'd1, 10'd0);
      chk("rst_ack", 32'(CFG_ACK_TOG), 32'd0);
      chk("rst_pend", 32'(CFG_PENDING), 32'd0);
      chk("rst_err", 32'(CFG_ERR), 32'd0);
      chk("rst_en", 32'(ENSAMP_sync), 32'd0);
      NRST_sync = 1'b1;
      tick(2);

      // Disabled: each request applies on the 4th edge after the toggle
      prev_div = 12'd0; prev_cnt = 4'd1; prev_p2 = 10'd0;
      for (int i = 0; i < 5; i++) begin
         lvl = ~lvl;
         request(lvl, tbl[i].div, tbl[i].cnt, tbl[i].p2);
         tick(3);
         chk($sformatf("t%0d_pend3", i), 32'(CFG_PENDING), 32'd1);
         chk_cfg($sformatf("t%0d_old", i), prev_div, prev_cnt, prev_p2);
         tick(1);
         chk_cfg($sformatf("t%0d_new", i), tbl[i].e_div, tbl[i].e_cnt, tbl[i].e_p2);
         chk($sformatf("t%0d_ack", i), 32'(CFG_ACK_TOG), 32'(lvl));
         chk($sformatf("t%0d_pend4", i), 32'(CFG_PENDING), 32'd0);
         chk($sformatf("t%0d_err", i), 32'(CFG_ERR), 32'(tbl[i].e_err));
         prev_div = tbl[i].e_div; prev_cnt = tbl[i].e_cnt; prev_p2 = tbl[i].e_p2;
         tick(2);
      end

      CFG_ERR_CLR = 1'b1;
      tick(1);
      CFG_ERR_CLR = 1'b0;
      chk("err_clr", 32'(CFG_ERR), 32'd0);

      // Enabled, continuous mode (active P2 = 0)
      ENSAMP = 1'b1; TEMP_RUN = 1'b1;
      tick(1);
      chk("en_sync1", 32'(ENSAMP_sync), 32'd0);
      tick(1);
      chk("en_sync2", 32'(ENSAMP_sync), 32'd1);
      lvl = ~lvl;
      request(lvl, 12'd2, 4'd4, 10'd0);
      tick(4);
      chk_cfg("cont", 12'd2, 4'd4, 10'd0);
      chk("cont_ack", 32'(CFG_ACK_TOG), 32'(lvl));
      lvl = ~lvl;
      request(lvl, 12'd3, 4'd2, 10'd20);
      tick(4);
      chk_cfg("cont2", 12'd3, 4'd2, 10'd20);

      // Enabled with P2=20: waits for a phase rising edge
      lvl = ~lvl;
      request(lvl, 12'd8, 4'd2, 10'd20);
      tick(10);
      chk("gate_pend", 32'(CFG_PENDING), 32'd1);
      chk_cfg("gate_hold", 12'd3, 4'd2, 10'd20);
      chk("gate_ack_hold", 32'(CFG_ACK_TOG), 32'd1);
      phase = 1'b1;
      tick(1);
      chk_cfg("gate_new", 12'd8, 4'd2, 10'd20);
      chk("gate_ack", 32'(CFG_ACK_TOG), 32'd0);
      chk("gate_pend0", 32'(CFG_PENDING), 32'd0);
      phase = 1'b0;
      tick(1);

      // Two toggles while pending merge into one apply
      lvl = ~lvl;
      request(lvl, 12'd10, 4'd5, 10'd20);
      tick(3);
      lvl = ~lvl;
      request(lvl, 12'd11, 4'd6, 10'd20);
      tick(10);
      chk("merge_pend", 32'(CFG_PENDING), 32'd1);
      chk_cfg("merge_hold", 12'd8, 4'd2, 10'd20);
      phase = 1'b1;
      tick(1);
      chk_cfg("merge_new", 12'd11, 4'd6, 10'd20);
      chk("merge_ack", 32'(CFG_ACK_TOG), 32'd0);
      chk("merge_pend0", 32'(CFG_PENDING), 32'd0);
      phase = 1'b0;
      tick(1);
      phase = 1'b1;
      tick(1);
      phase = 1'b0;
      chk_cfg("merge_once", 12'd11, 4'd6, 10'd20);
      chk("merge_ack2", 32'(CFG_ACK_TOG), 32'd0);

      // Reset while pending discards the request
      lvl = ~lvl;
      request(lvl, 12'd9, 4'd9, 10'd9);
      tick(5);
      chk("rp_pend", 32'(CFG_PENDING), 32'd1);
      NRST_sync = 1'b0;
      #1;
      chk_cfg("rp_rst", 12'd0, 4'd1, 10'd0);
      chk("rp_ack", 32'(CFG_ACK_TOG), 32'd0);
      chk("rp_pend0", 32'(CFG_PENDING), 32'd0);
      lvl = 1'b0;
      CFG_REQ_TOG = 1'b0;
      tick(2);
      NRST_sync = 1'b1;
      tick(8);
      chk_cfg("rp_after", 12'd0, 4'd1, 10'd0);
      chk("rp_ack_after", 32'(CFG_ACK_TOG), 32'd0);
      chk("rp_pend_after", 32'(CFG_PENDING), 32'd0);

      // A request level held high through reset is one new request after release
      NRST_sync = 1'b0;
      request(1'b1, 12'd4, 4'd2, 10'd6);
      tick(1);
      NRST_sync = 1'b1;
      tick(3);
      chk("hold_pend", 32'(CFG_PENDING), 32'd1);
      chk_cfg("hold_old", 12'd0, 4'd1, 10'd0);
      tick(1);
      chk_cfg("hold_new", 12'd4, 4'd2, 10'd6);
      chk("hold_ack", 32'(CFG_ACK_TOG), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
